// File: rtl/demux12_2bits_ff_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the registered 1:2 demultiplexer.
//   DATA_WIDTH_DEF : default word width on the input and on each lane
//   CNT_WIDTH_DEF  : default width of the per-lane accepted-word counters
//                    (used only when DEMUX_WORD_COUNT_EN is defined)
//   LANE0 / LANE1  : selector encodings of the two output lanes
//   DATA_RST_BIT   : bit value the lane data registers take at reset
// -----------------------------------------------------------------------------
package demux_pkg;

   localparam int DATA_WIDTH_DEF = 2;
   localparam int CNT_WIDTH_DEF  = 7;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

   // Reset data is all zeros; replicated to the actual word width at use.
   localparam logic DATA_RST_BIT = 1'b0;

endpackage : demux_pkg

// File: rtl/demux12_2bits_ff_if.sv
// -----------------------------------------------------------------------------
// demux12_2bits_ff_if
// Bundles the upstream handshake and the two downstream lanes of the
// demultiplexer. Optional macro: DEMUX_WORD_COUNT_EN adds count_lane0/1.
//
// Handshake: a word moves across a link at a posedge where both its valid and
// its ready are 1. valid/data are held stable by the sender while ready is 0.
//
//   upstream   : data_in, valid_in, selector (sender -> demux), ready_in (back)
//   lane 0     : data_out0, valid_out0 (demux -> consumer), ready_out0 (back)
//   lane 1     : data_out1, valid_out1 (demux -> consumer), ready_out1 (back)
//   counters   : count_lane0, count_lane1 (DEMUX_WORD_COUNT_EN only)
//
// Modports: slave  = the demultiplexer itself
//           master = the surrounding environment (sender and both consumers)
// -----------------------------------------------------------------------------
interface demux12_2bits_ff_if
   import demux_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef DEMUX_WORD_COUNT_EN
   , parameter int CNT_WIDTH = CNT_WIDTH_DEF
`endif
);

   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic                  selector;
   logic                  ready_in;

   logic [DATA_WIDTH-1:0] data_out0;
   logic                  valid_out0;
   logic                  ready_out0;

   logic [DATA_WIDTH-1:0] data_out1;
   logic                  valid_out1;
   logic                  ready_out1;

`ifdef DEMUX_WORD_COUNT_EN
   logic [CNT_WIDTH-1:0]  count_lane0;
   logic [CNT_WIDTH-1:0]  count_lane1;
`endif

   modport slave (
      input  data_in,
      input  valid_in,
      input  selector,
      output ready_in,
      output data_out0,
      output valid_out0,
      input  ready_out0,
      output data_out1,
      output valid_out1,
      input  ready_out1
`ifdef DEMUX_WORD_COUNT_EN
      , output count_lane0
      , output count_lane1
`endif
   );

   modport master (
      output data_in,
      output valid_in,
      output selector,
      input  ready_in,
      input  data_out0,
      input  valid_out0,
      output ready_out0,
      input  data_out1,
      input  valid_out1,
      output ready_out1
`ifdef DEMUX_WORD_COUNT_EN
      , input count_lane0
      , input count_lane1
`endif
   );

endinterface : demux12_2bits_ff_if

// File: rtl/demux12_2bits_ff_lane_reg.sv
// -----------------------------------------------------------------------------
// demux_lane_reg
// One-entry holding register for a single output lane.
// Optional macro: DEMUX_WORD_COUNT_EN adds the accepted-word counter.
//
//   clk, reset_L : clock, asynchronous active-low reset
//   load_i       : an accepted word is written this cycle (already qualified)
//   data_i       : word to write
//   drain_i      : consumer ready; empties the entry when it holds a word
//   valid_o      : entry holds a word
//   data_o       : held word (keeps its last value after a drain)
//   count_o      : words accepted into this lane, wraps (DEMUX_WORD_COUNT_EN)
// -----------------------------------------------------------------------------
module demux_lane_reg
   import demux_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef DEMUX_WORD_COUNT_EN
   , parameter int CNT_WIDTH = CNT_WIDTH_DEF
`endif
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  drain_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
`ifdef DEMUX_WORD_COUNT_EN
   , output logic [CNT_WIDTH-1:0] count_o
`endif
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;

   // A load wins over a drain on the same edge: the old word leaves and the
   // new word takes its place, so the lane sustains one word per cycle.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && drain_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         valid_q <= 1'b0;
         data_q  <= {DATA_WIDTH{DATA_RST_BIT}};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

`ifdef DEMUX_WORD_COUNT_EN
   logic [CNT_WIDTH-1:0] count_q, count_d;

   // Natural binary overflow gives the wrap from all-ones back to zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
`endif

endmodule : demux_lane_reg

// File: rtl/demux12_2bits_ff.sv
// -----------------------------------------------------------------------------
// demux12_2bits_ff
// Registered 1:2 demultiplexer: steers each accepted input word into the
// holding register of the lane named by selector. Each lane stalls on its
// own, so back-pressure on one consumer never disturbs the other lane.
// Optional macro: DEMUX_WORD_COUNT_EN adds per-lane accepted-word counters.
//
//   clk     : single clock, all state updates on posedge
//   reset_L : asynchronous active-low reset; clears both lanes, forces
//             ready_in low while asserted
//   bus     : demux12_2bits_ff_if.slave carrying data_in/valid_in/selector/
//             ready_in and data_outN/valid_outN/ready_outN for lanes 0 and 1
// -----------------------------------------------------------------------------
module demux12_2bits_ff
   import demux_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef DEMUX_WORD_COUNT_EN
   , parameter int CNT_WIDTH = CNT_WIDTH_DEF
`endif
) (
   input  logic               clk,
   input  logic               reset_L,
   demux12_2bits_ff_if.slave  bus
);

   logic lane0_free;
   logic lane1_free;
   logic ready_w;
   logic accept_w;
   logic load0_w;
   logic load1_w;

   // A lane can take a word when it is empty or is being emptied this edge.
   assign lane0_free = !bus.valid_out0 || bus.ready_out0;
   assign lane1_free = !bus.valid_out1 || bus.ready_out1;

   // ready_in looks only at the lane the selector currently names; the other
   // lane's stall state is irrelevant to this transfer.
   always_comb begin
      ready_w = 1'b0;
      if (reset_L) begin
         ready_w = (bus.selector == LANE1) ? lane1_free : lane0_free;
      end
   end

   assign bus.ready_in = ready_w;

   assign accept_w = bus.valid_in && ready_w;
   assign load0_w  = accept_w && (bus.selector == LANE0);
   assign load1_w  = accept_w && (bus.selector == LANE1);

   demux_lane_reg #(
      .DATA_WIDTH (DATA_WIDTH)
`ifdef DEMUX_WORD_COUNT_EN
      , .CNT_WIDTH (CNT_WIDTH)
`endif
   ) u_lane0 (
      .clk     (clk),
      .reset_L (reset_L),
      .load_i  (load0_w),
      .data_i  (bus.data_in),
      .drain_i (bus.ready_out0),
      .valid_o (bus.valid_out0),
      .data_o  (bus.data_out0)
`ifdef DEMUX_WORD_COUNT_EN
      , .count_o (bus.count_lane0)
`endif
   );

   demux_lane_reg #(
      .DATA_WIDTH (DATA_WIDTH)
`ifdef DEMUX_WORD_COUNT_EN
      , .CNT_WIDTH (CNT_WIDTH)
`endif
   ) u_lane1 (
      .clk     (clk),
      .reset_L (reset_L),
      .load_i  (load1_w),
      .data_i  (bus.data_in),
      .drain_i (bus.ready_out1),
      .valid_o (bus.valid_out1),
      .data_o  (bus.data_out1)
`ifdef DEMUX_WORD_COUNT_EN
      , .count_o (bus.count_lane1)
`endif
   );

endmodule : demux12_2bits_ff

// File: doc/demux12_2bits_ff.md
Name: demux12_2bits_ff

Overview:
- Registered 1:2 demultiplexer: the inverse of the team's registered 2:1 mux path.
- Steers a DATA_WIDTH-bit input word to one of two output lanes, chosen by `selector`.
- Each lane has a one-entry holding register with a valid/ready handshake, so a stalled lane never corrupts the other.
- Sits after the mux stage and fans a shared bus back out to two consumers.

Parameters:
- DATA_WIDTH, 2, width of the data word on input and on each lane.
- CNT_WIDTH, 7, width of the per-lane accepted-word counters (optional feature only).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  word to route.
- valid_in  input  1  data_in/selector are valid this cycle.
- selector  input  1  destination lane: 0 -> lane 0, 1 -> lane 1; sampled only when valid_in=1.
- ready_in  output  1  block can accept the word at the selected lane this cycle.
- data_out0  output  DATA_WIDTH  lane 0 registered word.
- valid_out0  output  1  lane 0 holds a word.
- ready_out0  input  1  lane 0 consumer accepts.
- data_out1  output  DATA_WIDTH  lane 1 registered word.
- valid_out1  output  1  lane 1 holds a word.
- ready_out1  input  1  lane 1 consumer accepts.

Behaviour:
- Reset:
  - reset_L low asynchronously clears valid_out0, valid_out1, data_out0 and data_out1 to 0.
  - Held contents are discarded; there is no replay after reset.
  - ready_in is forced to 0 while reset_L=0.
- ready_in (combinational):
  - selector=0: ready_in = !valid_out0 | ready_out0.
  - selector=1: ready_in = !valid_out1 | ready_out1.
  - ready_in depends only on the selected lane.
- Accept: valid_in & ready_in at a posedge.
  - Loads data_in into the lane named by `selector`.
  - That lane's valid_out is 1 from the next cycle; latency is exactly 1 cycle.
- Drain: valid_outN & ready_outN at a posedge.
  - Clears valid_outN, unless the same edge also accepts into lane N.
  - On simultaneous drain and load, valid_outN stays 1 and data_outN takes the new word. Full throughput is 1 word/cycle per lane.
- Stall: while valid_outN=1 and ready_outN=0, data_outN and valid_outN are held stable.
- Lane independence:
  - The non-selected lane drains freely.
  - The non-selected lane is never modified by an accept.
- Data retention: after a drain, data_outN retains its last value with valid_outN=0. Consumers must qualify data with valid.
- Inputs when valid_in=0: selector and data_in are don't-care and have no effect.
- Reset mid-transfer: a word in flight at the edge where reset_L falls is lost; the sender must resend.

Optional Feature:
- Macro: DEMUX_WORD_COUNT_EN.
- Defined:
  - Adds outputs `count_lane0` and `count_lane1`, each CNT_WIDTH bits.
  - Each counter increments by 1 on every accept into its lane.
  - Counters wrap from 2^CNT_WIDTH-1 to 0.
  - Counters are cleared to 0 asynchronously by reset_L.
- Not defined: the count ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `demux_pkg`:
  - DATA_WIDTH and CNT_WIDTH defaults.
  - Lane index constants LANE0=1'b0 and LANE1=1'b1.
  - Reset data value (all zeros).
- Sub-module `demux_lane_reg`: one-entry holding register, instantiated twice.
  - Inputs: load, data, drain.
  - Outputs: valid, data, plus the count when DEMUX_WORD_COUNT_EN is defined.
- Top level holds only the selector decode and the ready_in mux.

Test Plan:
- Reset check: hold reset_L=0 for 3 cycles with valid_in=1 and data_in=2'b11.
  - Required: ready_in=0, both valid_out=0, both data_out=2'b00.
  - Required with DEMUX_WORD_COUNT_EN: counts=0.
- Basic routing, both ready_out=1:
  - Send 2'b01 with selector=0 → data_out0=2'b01 and valid_out0=1 one cycle later.
  - Then send 2'b10 with selector=1 → data_out1=2'b10, valid_out1=1, lane 0 valid drops.
- Back-pressure, ready_out1=0:
  - Send 2'b11 to lane 1, then attempt 2'b00 to lane 1 → ready_in=0; data_out1 stays 2'b11.
  - A lane 0 send of 2'b10 in the same stall is accepted.
- Simultaneous drain and load on lane 0:
  - valid_out0=1 with 2'b01, ready_out0=1, send 2'b10 with selector=0.
  - Required: valid_out0 stays 1 and data_out0=2'b10 next cycle.
- Reset mid-stall:
  - lane 1 holds 2'b11 with ready_out1=0; drop reset_L between edges.
  - Required: valid_out1=0 and data_out1=2'b00 immediately, without waiting for a clock edge.
- Counter wrap (DEMUX_WORD_COUNT_EN, CNT_WIDTH=7):
  - 130 accepts to lane 0 → count_lane0=2; count_lane1=0.
